// File: rtl/vending_fsm_param_if.sv
// Front-panel bus of the vending controller: coin/selection/cancel/restock in,
// credit, change and one-cycle event pulses out.
interface vending_fsm_param_if #(
  parameter int N_DRINKS = 4,
  parameter int SEL_W    = 3,
  parameter int COIN_W   = 32
);
  logic [COIN_W-1:0]   coin;
  logic [SEL_W-1:0]    drink_choose;
  logic                cancel;
  logic                restock;
  logic [COIN_W-1:0]   total_coin;
  logic [COIN_W-1:0]   change;
  logic                change_valid;
  logic [N_DRINKS-1:0] avail;
  logic [N_DRINKS-1:0] sold_out;
  logic                dispense_valid;
  logic [SEL_W-1:0]    dispense_id;
  logic                coin_reject;
  logic                deny;

  modport master (
    output coin, drink_choose, cancel, restock,
    input  total_coin, change, change_valid, avail, sold_out,
           dispense_valid, dispense_id, coin_reject, deny
  );

  modport slave (
    input  coin, drink_choose, cancel, restock,
    output total_coin, change, change_valid, avail, sold_out,
           dispense_valid, dispense_id, coin_reject, deny
  );
endinterface

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit with ceiling, per-drink stock,
// one-cycle VEND state, registered change/dispense/reject/deny pulses.
module vending_fsm_param_slot #(
  parameter int COIN_W     = 32,
  parameter int PRICE_W    = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restock,
  input  logic               take,
  input  logic               blocked,
  input  logic [COIN_W-1:0]  credit,
  input  logic [PRICE_W-1:0] price,
  output logic               avail,
  output logic               sold_out
);
  logic [STOCK_W-1:0] stock;

  // restock wins over a same-edge decrement
  always_ff @(posedge clk) begin
    if (reset || restock) stock <= STOCK_W'(STOCK_INIT);
    else if (take)        stock <= stock - 1'b1;
  end

  assign sold_out = (stock == '0);
  assign avail    = !blocked && !sold_out && (credit >= COIN_W'(price));
endmodule

module vending_fsm_param #(
  parameter int N_DRINKS = 4,
  parameter int SEL_W    = 3,
  parameter int COIN_W   = 32,
  parameter int PRICE_W  = 8,
  parameter logic [N_DRINKS*PRICE_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 15,
  parameter int unsigned MAX_CREDIT = 255
) (
  input logic                 clk,
  input logic                 reset,
  vending_fsm_param_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CREDIT, VEND} state_t;

  localparam logic [COIN_W:0] MAX_SUM = (COIN_W+1)'(MAX_CREDIT);

  state_t                             state;
  logic [COIN_W-1:0]                  credit, change;
  logic                               change_valid, dispense_valid, coin_reject, deny;
  logic [SEL_W-1:0]                   dispense_id;
  logic [N_DRINKS-1:0][PRICE_W-1:0]   price_tab;
  logic [N_DRINKS-1:0]                hit, take, avail, sold_out;
  logic [COIN_W-1:0]                  sel_price;
  logic [COIN_W:0]                    coin_sum;
  logic                               coin_nz, cancel_go, vend_go, in_vend;

  assign price_tab = PRICES;
  assign in_vend   = (state == VEND);

  for (genvar i = 0; i < N_DRINKS; i++) begin : g_hit
    assign hit[i] = (bus.drink_choose == SEL_W'(i + 1));
  end

  // avail is already forced low in VEND, so no vend can start there
  assign cancel_go = bus.cancel && (credit != '0) && !in_vend;
  assign vend_go   = |(hit & avail) && !cancel_go;
  assign take      = hit & {N_DRINKS{vend_go}};
  assign coin_nz   = |bus.coin;
  assign coin_sum  = {1'b0, credit} + {1'b0, bus.coin};

  always_comb begin
    sel_price = '0;
    for (int i = 0; i < N_DRINKS; i++)
      if (hit[i]) sel_price = COIN_W'(price_tab[i]);
  end

  vending_fsm_param_slot #(
    .COIN_W(COIN_W), .PRICE_W(PRICE_W), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
  ) u_slot [N_DRINKS-1:0] (
    .clk      (clk),
    .reset    (reset),
    .restock  (bus.restock),
    .take     (take),
    .blocked  (in_vend),
    .credit   (credit),
    .price    (price_tab),
    .avail    (avail),
    .sold_out (sold_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      credit         <= '0;
      change         <= '0;
      change_valid   <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_id    <= '0;
      coin_reject    <= 1'b0;
      deny           <= 1'b0;
    end else begin
      change_valid   <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_id    <= '0;
      coin_reject    <= 1'b0;
      deny           <= 1'b0;
      if (in_vend) begin
        state       <= IDLE;
        coin_reject <= coin_nz;
      end else if (cancel_go) begin
        change       <= credit;
        change_valid <= 1'b1;
        credit       <= '0;
        state        <= IDLE;
        coin_reject  <= coin_nz;
      end else if (vend_go) begin
        change         <= credit - sel_price;
        change_valid   <= 1'b1;
        dispense_valid <= 1'b1;
        dispense_id    <= bus.drink_choose;
        credit         <= '0;
        state          <= VEND;
        coin_reject    <= coin_nz;
      end else begin
        // a refused selection still lets a same-cycle coin through
        deny <= (bus.drink_choose != '0);
        if (coin_nz) begin
          if (coin_sum <= MAX_SUM) begin
            credit <= coin_sum[COIN_W-1:0];
            state  <= CREDIT;
          end else begin
            coin_reject <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.total_coin     = credit;
  assign bus.change         = change;
  assign bus.change_valid   = change_valid;
  assign bus.dispense_valid = dispense_valid;
  assign bus.dispense_id    = dispense_id;
  assign bus.coin_reject    = coin_reject;
  assign bus.deny           = deny;
  assign bus.avail          = avail;
  assign bus.sold_out       = sold_out;
endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param: an abstract credit/stock model checked
// every cycle, plus literal spot checks on the documented scenarios.
module tb_vending_fsm_param;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_fsm_param_if #(.N_DRINKS(N), .SEL_W(3), .COIN_W(32)) bus ();

  vending_fsm_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int price [N] = '{10, 15, 20, 25};

  longint m_credit, m_change;
  int     m_stock [N];
  bit     m_vend, m_cv, m_dv, m_cr, m_deny;
  int     m_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_avail();
    logic [N-1:0] a = '0;
    for (int i = 0; i < N; i++)
      a[i] = !m_vend && (m_credit >= price[i]) && (m_stock[i] != 0);
    return a;
  endfunction

  function automatic logic [N-1:0] exp_sold();
    logic [N-1:0] a = '0;
    for (int i = 0; i < N; i++) a[i] = (m_stock[i] == 0);
    return a;
  endfunction

  // Next model state from the rules: what one edge does to credit, stock and pulses.
  task automatic model(input longint c, input int s, input bit cn, input bit rs, input bit rst);
    bit can_buy;
    m_cv = 0; m_dv = 0; m_id = 0; m_cr = 0; m_deny = 0;
    if (rst) begin
      m_credit = 0; m_change = 0; m_vend = 0;
      for (int i = 0; i < N; i++) m_stock[i] = 15;
      return;
    end
    can_buy = (s >= 1) && (s <= N) && !m_vend;
    if (can_buy) can_buy = (m_credit >= price[s-1]) && (m_stock[s-1] > 0);
    if (m_vend) begin
      m_vend = 0;
      m_cr = (c != 0);
    end else if (cn && m_credit > 0) begin
      m_change = m_credit; m_cv = 1; m_credit = 0; m_cr = (c != 0);
    end else if (can_buy) begin
      m_change = m_credit - price[s-1]; m_cv = 1; m_dv = 1; m_id = s;
      m_credit = 0; m_stock[s-1]--; m_vend = 1; m_cr = (c != 0);
    end else begin
      m_deny = (s != 0);
      if (c != 0) begin
        if (m_credit + c <= 255) m_credit += c;
        else m_cr = 1;
      end
    end
    if (rs) for (int i = 0; i < N; i++) m_stock[i] = 15;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("total_coin",     bus.total_coin,     m_credit);
      chk("change",         bus.change,         m_change);
      chk("change_valid",   bus.change_valid,   m_cv);
      chk("dispense_valid", bus.dispense_valid, m_dv);
      chk("dispense_id",    bus.dispense_id,    m_id);
      chk("coin_reject",    bus.coin_reject,    m_cr);
      chk("deny",           bus.deny,           m_deny);
      chk("avail",          bus.avail,          exp_avail());
      chk("sold_out",       bus.sold_out,       exp_sold());
    end
  end

  task automatic step(input int c, input int s, input bit cn, input bit rs, input bit rst);
    bus.coin         = 32'(c);
    bus.drink_choose = 3'(s);
    bus.cancel       = cn;
    bus.restock      = rs;
    reset            = rst;
    @(posedge clk);
    #1;
    model(c, s, cn, rs, rst);
    chk_en = 1'b1;
  endtask

  task automatic coin_in(input int c); step(c, 0, 0, 0, 0); endtask
  task automatic pick(input int s);    step(0, s, 0, 0, 0); endtask
  task automatic idle();               step(0, 0, 0, 0, 0); endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst total_coin", bus.total_coin, 0);
    chk("rst avail", bus.avail, 4'b0000);
    chk("rst sold_out", bus.sold_out, 4'b0000);
    idle();
    idle();
    step(0, 0, 1, 0, 0); // cancel with no credit: no pulse

    coin_in(10); chk("t1 credit", bus.total_coin, 10); chk("t1 avail", bus.avail, 4'b0001);
    coin_in(5);  chk("t2 credit", bus.total_coin, 15); chk("t2 avail", bus.avail, 4'b0011);
    coin_in(1);  chk("t3 credit", bus.total_coin, 16); chk("t3 avail", bus.avail, 4'b0011);
    coin_in(10); chk("t4 credit", bus.total_coin, 26); chk("t4 avail", bus.avail, 4'b1111);

    pick(3);
    chk("vend dv", bus.dispense_valid, 1);
    chk("vend id", bus.dispense_id, 3);
    chk("vend change", bus.change, 6);
    chk("vend credit", bus.total_coin, 0);
    pick(3);     // held through VEND: ignored
    chk("held no deny", bus.deny, 0);
    pick(3);     // held after VEND: denied
    chk("held deny", bus.deny, 1);

    coin_in(10); coin_in(2);
    pick(4);
    chk("milk deny", bus.deny, 1);
    chk("milk credit", bus.total_coin, 12);
    step(0, 0, 1, 0, 0);
    chk("cancel change", bus.change, 12);
    chk("cancel cv", bus.change_valid, 1);
    idle();

    coin_in(15);
    pick(5);     // out of range code
    chk("range deny", bus.deny, 1);
    step(0, 2, 0, 0, 0);
    chk("zero change", bus.change, 0);
    chk("zero change cv", bus.change_valid, 1);
    step(5, 0, 0, 0, 0); // coin during VEND
    chk("vend coin reject", bus.coin_reject, 1);

    for (int k = 0; k < 15; k++) begin
      coin_in(10);
      pick(1);
      idle();
    end
    coin_in(10);
    chk("tea sold_out", bus.sold_out, 4'b0001);
    chk("tea avail", bus.avail, 4'b0000);
    pick(1);
    chk("tea deny", bus.deny, 1);
    step(0, 0, 0, 1, 0);
    chk("restock sold_out", bus.sold_out, 4'b0000);
    chk("restock avail", bus.avail, 4'b0001);
    step(0, 1, 0, 1, 0); // restock on the same edge as a decrement
    idle();

    coin_in(250);
    coin_in(10);
    chk("ceiling reject", bus.coin_reject, 1);
    chk("ceiling credit", bus.total_coin, 250);
    coin_in(5);
    chk("ceiling 255", bus.total_coin, 255);
    step(0, 0, 1, 0, 0);

    coin_in(20);
    step(5, 2, 0, 0, 0);
    chk("sim dv", bus.dispense_valid, 1);
    chk("sim id", bus.dispense_id, 2);
    chk("sim change", bus.change, 5);
    chk("sim reject", bus.coin_reject, 1);
    idle();

    coin_in(7);
    step(3, 0, 1, 0, 0);
    chk("cc change", bus.change, 7);
    chk("cc reject", bus.coin_reject, 1);
    chk("cc credit", bus.total_coin, 0);

    coin_in(25);
    pick(4);
    step(0, 0, 0, 0, 1); // reset during VEND
    chk("rst vend dv", bus.dispense_valid, 0);
    chk("rst vend change", bus.change, 0);
    coin_in(30);
    step(0, 0, 0, 0, 1); // reset drops credit without a refund pulse
    chk("rst credit cv", bus.change_valid, 0);
    idle();
    idle();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/vending_fsm_param.md
# vending_fsm_param

Parametrised vending-machine controller, the next generation of the team's single-product-table `FSM`. It accumulates coin credit and exposes a per-drink availability mask. On a valid selection it dispenses exactly one item and returns change. It also adds per-drink stock counters, a credit ceiling with coin rejection, restock, and explicit denial and pulse outputs for the front panel and test benches.

## Interface
Parameters:
- `N_DRINKS`, 4: number of products; selection codes 1..N_DRINKS, 0 = no choice.
- `SEL_W`, 3: width of `drink_choose`; must satisfy 2^SEL_W > N_DRINKS.
- `COIN_W`, 32: width of `coin`, `total_coin` and `change`.
- `PRICE_W`, 8: width of one price field.
- `PRICES`, {8'd25, 8'd20, 8'd15, 8'd10}: packed price table; drink 1 (tea) is in the LSBs, then coke 15, coffee 20, milk 25.
- `STOCK_W`, 4: width of each stock counter.
- `STOCK_INIT`, 15: stock value loaded by reset and by `restock`.
- `MAX_CREDIT`, 255: highest credit accepted.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `coin` input COIN_W: coin value inserted this cycle; 0 = none; sampled every cycle.
- `drink_choose` input SEL_W: selection code, sampled every cycle.
- `cancel` input 1: refund request, sampled every cycle.
- `restock` input 1: reload all stock counters.
- `total_coin` output COIN_W: current credit, registered.
- `change` output COIN_W: last refund/change amount, registered; held until overwritten or reset.
- `change_valid` output 1: one-cycle pulse when `change` is updated.
- `avail` output N_DRINKS: bit i-1 = credit ≥ price(i) and stock(i) ≠ 0. Combinational from registers; forced to 0 in VEND.
- `sold_out` output N_DRINKS: bit i-1 = stock(i) == 0. Combinational from registers.
- `dispense_valid` output 1: one-cycle pulse; one item released.
- `dispense_id` output SEL_W: code of the item dispensed; 0 when `dispense_valid` = 0.
- `coin_reject` output 1: one-cycle pulse; the coin sampled on the previous edge was refused and is physically returned.
- `deny` output 1: one-cycle pulse; the selection sampled on the previous edge was refused.

## Operation
- States:
  - IDLE: credit = 0.
  - CREDIT: credit > 0.
  - VEND: one cycle; pulses are active.
- Per-edge priority in IDLE/CREDIT: `cancel` > valid `drink_choose` ≠ 0 > `coin`.
- `cancel` with credit > 0:
  - `change` ← credit, `change_valid` = 1, credit ← 0, next state IDLE.
  - A coin in the same cycle is rejected.
  - `cancel` with credit = 0 has no effect; it produces no pulse.
- Selection s, where 1 ≤ s ≤ N_DRINKS and `avail`[s-1] = 1:
  - Next state VEND.
  - `dispense_valid` = 1 and `dispense_id` = s.
  - `change` ← credit − price(s), `change_valid` = 1, even when the change is 0.
  - stock(s) decrements and credit ← 0.
  - A coin in the same cycle is rejected.
- Selection s that is unavailable, or s > N_DRINKS: `deny` = 1; nothing else changes. A coin in that cycle is still processed normally.
- Coin c ≠ 0 with no higher-priority event:
  - If credit + c ≤ MAX_CREDIT: credit += c; next state CREDIT.
  - Otherwise `coin_reject` = 1 and credit is unchanged.
  - The sum is computed at COIN_W+1 bits, so no wrap is possible.
- VEND:
  - Lasts exactly one cycle, then goes to IDLE.
  - Coins are rejected; `drink_choose` and `cancel` are ignored without `deny`.
- `restock`:
  - In any state, all stocks ← STOCK_INIT on that edge.
  - Overrides a same-edge decrement.
  - Does not affect credit or state.
- Stock never underflows, because selection requires stock ≠ 0.

## Timing
- Reset values:
  - state IDLE.
  - `total_coin` 0, `change` 0.
  - `change_valid`, `dispense_valid`, `coin_reject` and `deny` all 0.
  - `dispense_id` 0.
  - all stocks STOCK_INIT, so `avail` = 0 and `sold_out` = 0.
- `reset` overrides every other input, including mid-VEND. In-flight credit is discarded with no refund pulse.
- Latency:
  - Input sampled at edge k; the registered result is visible after edge k.
  - Pulses are high for exactly the cycle between edges k and k+1.
- A held `coin` adds once per cycle it is non-zero.
- A held valid selection vends once. After VEND, credit is 0, so a still-held selection produces `deny`.
- Back-to-back coins on consecutive cycles are all accepted, up to MAX_CREDIT.

## Test plan
- Reset, then coins 10, 5, 1, 10 on consecutive cycles:
  - `total_coin` steps 10, 15, 16, 26.
  - `avail` steps 0001, 0011, 0011, 1111.
- From credit 26, select 3 (coffee):
  - one cycle with `dispense_valid` = 1, `dispense_id` = 3, `change` = 6, `change_valid` = 1, `total_coin` = 0.
  - stock(3) = 14; next cycle state IDLE.
- Credit 12, select 4 (milk): `deny` = 1 and credit stays 12. Then `cancel`: `change` = 12, `change_valid` = 1, `total_coin` = 0.
- Sold-out and restock:
  - 15 vends of tea at 10 each give `sold_out`[0] = 1 and `avail`[0] = 0 with credit 10; select 1 then gives `deny`.
  - `restock` sets `sold_out` = 0000.
- Credit 250, coin 10: `coin_reject` = 1 and credit stays 250. Coin 5: credit 255.
- Simultaneous events:
  - Credit 20 with coin 5 + select 2 on the same edge: dispense 2, `change` = 5, `coin_reject` = 1.
  - Coin + `cancel` on the same edge: refund of the old credit only, plus `coin_reject`.
  - `reset` during VEND clears all outputs.
